// File: rtl/bird_pkg.sv
// Shared constants for the bird column input path.
// The defaults are the small simulation values; the board build overrides the top-level parameters.
package bird_pkg;
    localparam int BIRD_DEBOUNCE_CYCLES = 4;
    localparam int BIRD_GRAVITY_CYCLES  = 16;
endpackage

// File: rtl/bird_input_ctrl_if.sv
// Flap/enable inputs and up/bottom move pulses between the game logic and the bird input controller.
interface bird_input_ctrl_if;
    logic key;
    logic enable;
    logic up;
    logic bottom;

    modport master (output key, output enable, input up, input bottom);
    modport slave  (input key, input enable, output up, output bottom);
endinterface

// File: rtl/key_debounce.sv
// Synchronizes the raw flap button, debounces it and emits a one-cycle pulse on each debounced press.
module key_debounce
    import bird_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BIRD_DEBOUNCE_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key,
    output logic rise
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          s1_r;
    logic          s2_r;
    logic          db_r;
    logic          db_q_r;
    logic [DW-1:0] dcnt_r;

    // Two-flop synchronizer, debounce counter and the delayed level used for edge detection.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            db_r   <= 1'b0;
            db_q_r <= 1'b0;
            dcnt_r <= {DW{1'b0}};
        end else begin
            s1_r   <= key;
            s2_r   <= s1_r;
            db_q_r <= db_r;
            if (s2_r != db_r) begin
                if (dcnt_r == DCNT_LAST) begin
                    db_r   <= s2_r;
                    dcnt_r <= {DW{1'b0}};
                end else begin
                    dcnt_r <= dcnt_r + DW'(1);
                end
            end else begin
                dcnt_r <= {DW{1'b0}};
            end
        end
    end

    // Only the press edge matters; releases are silent.
    assign rise = db_r & ~db_q_r;
endmodule

// File: rtl/bird_input_ctrl.sv
// Turns the flap button and a gravity timer into mutually exclusive one-cycle up/bottom pulses
// for the bird column cells.
module bird_input_ctrl
    import bird_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BIRD_DEBOUNCE_CYCLES,
    parameter int GRAVITY_CYCLES  = BIRD_GRAVITY_CYCLES
) (
    input  logic              Clock,
    input  logic              Reset,
    bird_input_ctrl_if.slave  bus
);
    localparam int GW = $clog2(GRAVITY_CYCLES);
    localparam logic [GW-1:0] GCNT_LAST = GW'(GRAVITY_CYCLES - 1);

    logic          rise_s;
    logic          fall_s;
    logic [GW-1:0] gcnt_r;
    logic          up_r;
    logic          bottom_r;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .Clock (Clock),
        .Reset (Reset),
        .key   (bus.key),
        .rise  (rise_s)
    );

    assign fall_s = (gcnt_r == GCNT_LAST);

    // Gravity interval counter and output pulses; a flap restarts the interval and wins over a fall.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            gcnt_r   <= {GW{1'b0}};
            up_r     <= 1'b0;
            bottom_r <= 1'b0;
        end else begin
            if (!bus.enable) begin
                gcnt_r <= {GW{1'b0}};
            end else if (rise_s) begin
                gcnt_r <= {GW{1'b0}};
            end else if (fall_s) begin
                gcnt_r <= {GW{1'b0}};
            end else begin
                gcnt_r <= gcnt_r + GW'(1);
            end
            up_r     <= bus.enable & rise_s;
            bottom_r <= bus.enable & ~rise_s & fall_s;
        end
    end

    assign bus.up     = up_r;
    assign bus.bottom = bottom_r;
endmodule

// File: tb/tb_bird_input_ctrl.sv
// Directed bench for bird_input_ctrl with the default 4-sample debounce and 16-cycle gravity period.
module tb_bird_input_ctrl;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n;
    logic any_up, any_bottom, any_gcnt;
    logic up_prev = 1'b0;
    logic bottom_prev = 1'b0;

    bird_input_ctrl_if bus ();

    bird_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .GRAVITY_CYCLES (16)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Edges until the selected pulse (1 = bottom, 0 = up) is seen; -1 if not within limit.
    task automatic wait_pulse(input bit sel, input int limit, output int cnt);
        logic found;
        found = 1'b0;
        cnt = 0;
        while (cnt < limit && !found) begin
            step();
            cnt++;
            found = sel ? bus.bottom : bus.up;
        end
        if (!found) cnt = -1;
    endtask

    // Continuous pulse invariants: never both, never two cycles wide.
    always @(negedge Clock) begin
        total += 3;
        assert (!(bus.up && bus.bottom)) else begin
            bad++;
            $error("FAIL excl: observed up=%0b bottom=%0b expected not both", bus.up, bus.bottom);
        end
        assert (!(bus.up && up_prev)) else begin
            bad++;
            $error("FAIL up_width: observed 2-cycle up expected 1");
        end
        assert (!(bus.bottom && bottom_prev)) else begin
            bad++;
            $error("FAIL bottom_width: observed 2-cycle bottom expected 1");
        end
        up_prev     = bus.up;
        bottom_prev = bus.bottom;
    end

    initial begin
        bus.key    = 1'b0;
        bus.enable = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_up", bus.up, 1'b0);
        chk("rst_bottom", bus.bottom, 1'b0);
        chk("rst_gcnt", dut.gcnt_r, 0);

        // Fall period from reset release
        Reset      = 1'b0;
        bus.enable = 1'b1;
        wait_pulse(1'b1, 20, n);
        chk("first_fall", n, 16);
        chk("first_fall_gcnt", dut.gcnt_r, 0);
        wait_pulse(1'b1, 20, n);
        chk("second_fall", n, 16);

        // Reset mid-count at gcnt=9
        repeat (9) step();
        chk("gcnt9", dut.gcnt_r, 9);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_gcnt", dut.gcnt_r, 0);
        chk("midrst_up", bus.up, 1'b0);
        chk("midrst_bottom", bus.bottom, 1'b0);
        step();
        Reset = 1'b0;
        wait_pulse(1'b1, 20, n);
        chk("fall_after_rst", n, 16);

        // Clean press: up 6 edges after E0 (7 edges counting E0)
        bus.key = 1'b1;
        wait_pulse(1'b0, 12, n);
        chk("press_latency", n, 7);
        chk("press_no_bottom", bus.bottom, 1'b0);
        wait_pulse(1'b1, 20, n);
        chk("fall_after_up", n, 16);
        bus.key = 1'b0;
        wait_pulse(1'b0, 20, n);
        chk("release_no_up", n, -1);

        // Bounce rejection
        any_up = 1'b0;
        for (int r = 0; r < 5; r++) begin
            bus.key = 1'b1;
            repeat (3) begin step(); any_up |= bus.up; end
            bus.key = 1'b0;
            repeat (2) begin step(); any_up |= bus.up; end
        end
        repeat (6) begin step(); any_up |= bus.up; end
        chk("bounce_no_up", any_up, 1'b0);
        bus.key = 1'b1;
        wait_pulse(1'b0, 10, n);
        chk("bounce_then_hold", n, 7);
        repeat (3) step();
        bus.key = 1'b0;
        repeat (10) step();

        // Simultaneous flap and fall: rise lands on gcnt=15
        wait_pulse(1'b1, 20, n);
        chk("sync_fall", n >= 1 ? 1 : 0, 1);
        repeat (9) step();
        bus.key = 1'b1;
        wait_pulse(1'b0, 12, n);
        chk("sim_up_latency", n, 7);
        chk("sim_bottom_suppressed", bus.bottom, 1'b0);
        chk("sim_gcnt_restart", dut.gcnt_r, 0);
        wait_pulse(1'b1, 20, n);
        chk("sim_next_fall", n, 16);
        bus.key = 1'b0;
        repeat (10) step();

        // Disable window with a debounced press inside
        bus.enable = 1'b0;
        any_up = 1'b0; any_bottom = 1'b0; any_gcnt = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5)  bus.key = 1'b1;
            if (c == 20) bus.key = 1'b0;
            step();
            any_up     |= bus.up;
            any_bottom |= bus.bottom;
            any_gcnt   |= (dut.gcnt_r != 4'd0);
        end
        chk("dis_no_up", any_up, 1'b0);
        chk("dis_no_bottom", any_bottom, 1'b0);
        chk("dis_gcnt_held", any_gcnt, 1'b0);
        bus.enable = 1'b1;
        wait_pulse(1'b1, 20, n);
        chk("reenable_fall", n, 16);

        // Random key/enable; invariants checked by the monitor
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)  bus.key = ~bus.key;
            if ($urandom_range(0, 63) == 0) bus.enable = ~bus.enable;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
